fetcher: RTL and testbench

FETCHER -- requirements
Module: fetcher

---
 rtl/gpu_pkg.sv | 18 +
 rtl/fetcher_if.sv | 35 +++
 rtl/fetcher_lbuf.sv | 46 ++++
 rtl/fetcher.sv | 127 ++++++++++++
 tb/tb_fetcher.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
// Shared encodings for the compute-unit front end: core_state values seen by
// the fetcher, the fetcher FSM state enum and default bus widths.
package gpu_pkg;

   localparam int MEM_ADDR_WIDTH_DEF = 8;
   localparam int MEM_DATA_WIDTH_DEF = 16;

   localparam logic [3:0] FETCH  = 4'd1;
   localparam logic [3:0] DECODE = 4'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQUEST = 2'd1,
      ST_AWAIT   = 2'd2,
      ST_DONE    = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetcher_if.sv
// Fetcher <-> memory controller handshake bundle. The fetcher side uses the
// master modport, the memory controller (or a bench) uses slave.
interface fetcher_if
   import gpu_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = MEM_ADDR_WIDTH_DEF,
   parameter int MEM_DATA_WIDTH = MEM_DATA_WIDTH_DEF
);

   logic                      fetch_req_val;
   logic                      fetch_req_rdy;
   logic [MEM_ADDR_WIDTH-1:0] fetch_req_addr;
   logic                      fetch_resp_rdy;
   logic                      fetch_resp_val;
   logic [MEM_DATA_WIDTH-1:0] fetch_resp_inst;

   modport master (
      output fetch_req_val,
      output fetch_req_addr,
      output fetch_resp_rdy,
      input  fetch_req_rdy,
      input  fetch_resp_val,
      input  fetch_resp_inst
   );

   modport slave (
      input  fetch_req_val,
      input  fetch_req_addr,
      input  fetch_resp_rdy,
      output fetch_req_rdy,
      output fetch_resp_val,
      output fetch_resp_inst
   );

endinterface

// File: rtl/fetcher_lbuf.sv
// Single-entry last-instruction buffer (valid/pc/inst). Only built when
// FETCHER_LAST_INST_EN is defined; otherwise this file is empty so no storage
// exists. A flush clears valid and wins over a same-cycle write.
`ifdef FETCHER_LAST_INST_EN
module fetcher_lbuf #(
   parameter int MEM_ADDR_WIDTH = 8,
   parameter int MEM_DATA_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      wr_en,
   input  logic [MEM_ADDR_WIDTH-1:0] wr_pc,
   input  logic [MEM_DATA_WIDTH-1:0] wr_inst,
   input  logic [MEM_ADDR_WIDTH-1:0] rd_pc,
   output logic                      hit,
   output logic [MEM_DATA_WIDTH-1:0] rd_inst
);

   logic                      valid_q;
   logic [MEM_ADDR_WIDTH-1:0] pc_q;
   logic [MEM_DATA_WIDTH-1:0] inst_q;

   // entry update; flush is applied last so it overrides a write
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         inst_q  <= '0;
      end else begin
         if (wr_en) begin
            valid_q <= 1'b1;
            pc_q    <= wr_pc;
            inst_q  <= wr_inst;
         end
         if (flush) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign hit     = valid_q && (pc_q == rd_pc);
   assign rd_inst = inst_q;

endmodule
`endif

// File: rtl/fetcher.sv
// Instruction fetcher: latches the PC on a FETCH request, runs a val/rdy
// request/response exchange with the memory controller and holds the
// returned instruction until the core moves to DECODE.
// Optional feature macro: FETCHER_LAST_INST_EN (last-instruction buffer).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for core_state==FETCH; pc latched on leaving
//   REQUEST  | fetch_req_val high, waiting for fetch_req_rdy
//   AWAIT    | request held, fetch_resp_rdy high, waiting for response
//   DONE     | instruction valid and stable until core_state==DECODE
module fetcher
   import gpu_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = MEM_ADDR_WIDTH_DEF,
   parameter int MEM_DATA_WIDTH = MEM_DATA_WIDTH_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [3:0]                core_state,
   input  logic [MEM_ADDR_WIDTH-1:0] pc,
   input  logic                      inst_flush,
   fetcher_if.master                 mem,
   output logic [1:0]                fetcher_state,
   output logic [MEM_DATA_WIDTH-1:0] instruction,
   output logic [15:0]               stall_cycles
);

   fetch_state_e              state_q, state_d;
   logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [MEM_DATA_WIDTH-1:0] inst_q, inst_d;
   logic [15:0]               stall_q;
   logic                      lb_wr;
   logic                      lb_hit;
   logic [MEM_DATA_WIDTH-1:0] lb_inst;

`ifdef FETCHER_LAST_INST_EN
   fetcher_lbuf #(
      .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH),
      .MEM_DATA_WIDTH (MEM_DATA_WIDTH)
   ) u_lbuf (
      .clk     (clk),
      .reset   (reset),
      .flush   (inst_flush),
      .wr_en   (lb_wr),
      .wr_pc   (addr_q),
      .wr_inst (mem.fetch_resp_inst),
      .rd_pc   (pc),
      .hit     (lb_hit),
      .rd_inst (lb_inst)
   );
`else
   assign lb_hit  = 1'b0;
   assign lb_inst = '0;
   wire unused_lbuf = &{1'b0, inst_flush, lb_wr};
`endif

   // next-state, address latch and instruction capture
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      inst_d  = inst_q;
      lb_wr   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (core_state == FETCH) begin
               addr_d = pc;
               if (lb_hit) begin
                  state_d = ST_DONE;
                  inst_d  = lb_inst;
               end else begin
                  state_d = ST_REQUEST;
               end
            end
         end
         ST_REQUEST: begin
            if (mem.fetch_req_val && mem.fetch_req_rdy) begin
               state_d = ST_AWAIT;
            end
         end
         ST_AWAIT: begin
            if (mem.fetch_resp_val) begin
               inst_d  = mem.fetch_resp_inst;
               lb_wr   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (core_state == DECODE) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         inst_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         inst_q  <= inst_d;
      end
   end

   // saturating count of cycles spent waiting on memory
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
      end else if ((state_q == ST_REQUEST || state_q == ST_AWAIT) &&
                   (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign mem.fetch_req_val  = (state_q == ST_REQUEST) || (state_q == ST_AWAIT);
   assign mem.fetch_resp_rdy = (state_q == ST_AWAIT);
   assign mem.fetch_req_addr = addr_q;
   assign fetcher_state      = state_q;
   assign instruction        = inst_q;
   assign stall_cycles       = stall_q;

endmodule

// File: tb/tb_fetcher.sv
// Directed bench for fetcher: reset, basic fetch, backpressure, DONE hold,
// last-instruction buffer (or its absence), reset mid-AWAIT and saturation.
module tb_fetcher;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  core_state;
   logic [7:0]  pc;
   logic        inst_flush;
   logic [1:0]  fetcher_state;
   logic [15:0] instruction;
   logic [15:0] stall_cycles;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_stall = 0;

   fetcher_if #(.MEM_ADDR_WIDTH(8), .MEM_DATA_WIDTH(16)) mem_if ();

   fetcher #(.MEM_ADDR_WIDTH(8), .MEM_DATA_WIDTH(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .core_state    (core_state),
      .pc            (pc),
      .inst_flush    (inst_flush),
      .mem           (mem_if.master),
      .fetcher_state (fetcher_state),
      .instruction   (instruction),
      .stall_cycles  (stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // full miss fetch with an always-ready memory, ending back in IDLE
   task automatic miss_fetch(input logic [7:0] a, input logic [15:0] d, input string tag);
      core_state = 4'd1; pc = a; mem_if.fetch_req_rdy = 1'b1;
      tick();
      check({tag, "_req"}, {30'd0, fetcher_state}, 32'd1);
      core_state = 4'd0;
      tick();
      check({tag, "_await"}, {30'd0, fetcher_state}, 32'd2);
      mem_if.fetch_resp_val = 1'b1; mem_if.fetch_resp_inst = d;
      tick();
      mem_if.fetch_resp_val = 1'b0;
      exp_stall += 2;
      check({tag, "_done"}, {30'd0, fetcher_state}, 32'd3);
      check({tag, "_inst"}, {16'd0, instruction}, {16'd0, d});
      core_state = 4'd2;
      tick();
      core_state = 4'd0;
   endtask

   initial begin
      reset = 1'b1; core_state = 4'd0; pc = 8'h00; inst_flush = 1'b0;
      mem_if.fetch_req_rdy = 1'b0; mem_if.fetch_resp_val = 1'b0;
      mem_if.fetch_resp_inst = 16'h0000;
      tick(); tick();

      check("rst_state", {30'd0, fetcher_state}, 32'd0);
      check("rst_req_val", {31'd0, mem_if.fetch_req_val}, 32'd0);
      check("rst_resp_rdy", {31'd0, mem_if.fetch_resp_rdy}, 32'd0);
      check("rst_addr", {24'd0, mem_if.fetch_req_addr}, 32'd0);
      check("rst_inst", {16'd0, instruction}, 32'd0);
      check("rst_stall", {16'd0, stall_cycles}, 32'd0);

      // basic fetch: pc=10, response A5A5 two cycles after FETCH
      reset = 1'b0; core_state = 4'd1; pc = 8'h10; mem_if.fetch_req_rdy = 1'b1;
      tick();
      check("basic_req_state", {30'd0, fetcher_state}, 32'd1);
      check("basic_req_val", {31'd0, mem_if.fetch_req_val}, 32'd1);
      check("basic_req_addr", {24'd0, mem_if.fetch_req_addr}, 32'h10);
      check("basic_resp_rdy_req", {31'd0, mem_if.fetch_resp_rdy}, 32'd0);
      pc = 8'h55; core_state = 4'd0;
      tick();
      check("basic_await_state", {30'd0, fetcher_state}, 32'd2);
      check("basic_await_addr", {24'd0, mem_if.fetch_req_addr}, 32'h10);
      check("basic_await_val", {31'd0, mem_if.fetch_req_val}, 32'd1);
      check("basic_resp_rdy", {31'd0, mem_if.fetch_resp_rdy}, 32'd1);
      mem_if.fetch_resp_val = 1'b1; mem_if.fetch_resp_inst = 16'hA5A5;
      tick();
      mem_if.fetch_resp_val = 1'b0;
      check("basic_done_state", {30'd0, fetcher_state}, 32'd3);
      check("basic_inst", {16'd0, instruction}, 32'hA5A5);
      check("basic_done_val", {31'd0, mem_if.fetch_req_val}, 32'd0);
      check("basic_done_rdy", {31'd0, mem_if.fetch_resp_rdy}, 32'd0);
      check("basic_stall", {16'd0, stall_cycles}, 32'd2);
      exp_stall = 2;

      // DONE hold with FETCH still asserted, then DECODE
      core_state = 4'd1; pc = 8'h77;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("hold_state", {30'd0, fetcher_state}, 32'd3);
         check("hold_inst", {16'd0, instruction}, 32'hA5A5);
         check("hold_no_req", {31'd0, mem_if.fetch_req_val}, 32'd0);
      end
      core_state = 4'd2;
      tick();
      check("hold_to_idle", {30'd0, fetcher_state}, 32'd0);
      core_state = 4'd0;

      // backpressure, with a stray response during REQUEST
      core_state = 4'd1; pc = 8'h30; mem_if.fetch_req_rdy = 1'b0;
      tick();
      core_state = 4'd0; pc = 8'h99;
      mem_if.fetch_resp_val = 1'b1; mem_if.fetch_resp_inst = 16'h1234;
      for (int i = 0; i < 5; i++) begin
         check("bp_state", {30'd0, fetcher_state}, 32'd1);
         check("bp_val", {31'd0, mem_if.fetch_req_val}, 32'd1);
         check("bp_addr", {24'd0, mem_if.fetch_req_addr}, 32'h30);
         check("bp_resp_rdy", {31'd0, mem_if.fetch_resp_rdy}, 32'd0);
         if (i < 4) tick();
      end
      mem_if.fetch_resp_val = 1'b0; mem_if.fetch_req_rdy = 1'b1;
      tick();
      check("bp_await", {30'd0, fetcher_state}, 32'd2);
      check("bp_inst_kept", {16'd0, instruction}, 32'hA5A5);
      check("bp_stall", {16'd0, stall_cycles}, 32'd7);
      mem_if.fetch_resp_val = 1'b1; mem_if.fetch_resp_inst = 16'hBEEF;
      tick();
      mem_if.fetch_resp_val = 1'b0;
      check("bp_inst", {16'd0, instruction}, 32'hBEEF);
      check("bp_stall_done", {16'd0, stall_cycles}, 32'd8);
      exp_stall = 8;
      core_state = 4'd2;
      tick();
      core_state = 4'd0;

      // same pc fetched twice
      miss_fetch(8'h20, 16'h2020, "lb1");
      core_state = 4'd1; pc = 8'h20;
      tick();
`ifdef FETCHER_LAST_INST_EN
      check("lb_hit_state", {30'd0, fetcher_state}, 32'd3);
      check("lb_hit_no_req", {31'd0, mem_if.fetch_req_val}, 32'd0);
      check("lb_hit_inst", {16'd0, instruction}, 32'h2020);
      check("lb_hit_stall", {16'd0, stall_cycles}, exp_stall);
      core_state = 4'd2;
      tick();
      core_state = 4'd0;
`else
      check("nolb_state", {30'd0, fetcher_state}, 32'd1);
      check("nolb_req", {31'd0, mem_if.fetch_req_val}, 32'd1);
      core_state = 4'd0;
      tick();
      mem_if.fetch_resp_val = 1'b1; mem_if.fetch_resp_inst = 16'h2020;
      tick();
      mem_if.fetch_resp_val = 1'b0;
      exp_stall += 2;
      check("nolb_stall", {16'd0, stall_cycles}, exp_stall);
      core_state = 4'd2;
      tick();
      core_state = 4'd0;
`endif

      // flush between fetches forces a request
      inst_flush = 1'b1;
      tick();
      inst_flush = 1'b0;
      miss_fetch(8'h20, 16'h2121, "flush");

      // flush coinciding with the buffer write leaves the entry invalid
      core_state = 4'd1; pc = 8'h60;
      tick();
      core_state = 4'd0;
      tick();
      mem_if.fetch_resp_val = 1'b1; mem_if.fetch_resp_inst = 16'h6060; inst_flush = 1'b1;
      tick();
      mem_if.fetch_resp_val = 1'b0; inst_flush = 1'b0;
      exp_stall += 2;
      check("fpri_inst", {16'd0, instruction}, 32'h6060);
      core_state = 4'd2;
      tick();
      miss_fetch(8'h60, 16'h6161, "fpri");
      check("stall_track", {16'd0, stall_cycles}, exp_stall);

      // reset in AWAIT, response arriving with and after reset
      core_state = 4'd1; pc = 8'h50;
      tick();
      core_state = 4'd0;
      tick();
      check("rmid_await", {30'd0, fetcher_state}, 32'd2);
      reset = 1'b1; mem_if.fetch_resp_val = 1'b1; mem_if.fetch_resp_inst = 16'hDEAD;
      tick();
      check("rmid_state", {30'd0, fetcher_state}, 32'd0);
      check("rmid_val", {31'd0, mem_if.fetch_req_val}, 32'd0);
      check("rmid_rdy", {31'd0, mem_if.fetch_resp_rdy}, 32'd0);
      check("rmid_addr", {24'd0, mem_if.fetch_req_addr}, 32'd0);
      check("rmid_inst", {16'd0, instruction}, 32'd0);
      check("rmid_stall", {16'd0, stall_cycles}, 32'd0);
      reset = 1'b0;
      tick();
      mem_if.fetch_resp_val = 1'b0;
      check("rmid_late_state", {30'd0, fetcher_state}, 32'd0);
      check("rmid_late_inst", {16'd0, instruction}, 32'd0);

      // buffer emptied by reset: pc 60 must miss
      core_state = 4'd1; pc = 8'h60;
      tick();
      check("rst_lb_miss", {30'd0, fetcher_state}, 32'd1);
      reset = 1'b1; core_state = 4'd0;
      tick();
      reset = 1'b0;

      // saturation: hold the request for 70000 cycles
      core_state = 4'd1; pc = 8'h00; mem_if.fetch_req_rdy = 1'b0;
      tick();
      core_state = 4'd0;
      for (int i = 0; i < 65534; i++) tick();
      check("sat_edge_minus1", {16'd0, stall_cycles}, 32'hFFFE);
      tick();
      check("sat_edge", {16'd0, stall_cycles}, 32'hFFFF);
      for (int i = 0; i < 4465; i++) tick();
      check("sat_hold", {16'd0, stall_cycles}, 32'hFFFF);
      check("sat_state", {30'd0, fetcher_state}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
